// File: rtl/beamform_pkg.sv
// beamform_pkg: shared beamformer constants, steering-delay rule and sweep states
package beamform_pkg;
  localparam int NUM_RX = 4;
  localparam int BUF_DEPTH = 32;
  localparam int DELAY_W = $clog2(BUF_DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CAPTURE, REPORT, DONE} sweep_state_t;
  function automatic int steer_delay(input int angle, input int ch, input int num_angles);
    int s;
    s = angle - num_angles / 2;
    return s >= 0 ? s * ch : -s * (NUM_RX - 1 - ch);
  endfunction
endpackage

// File: rtl/beam_sweep_controller_if.sv
// beam_sweep_controller_if: command, sample stream and result bundle of the sweep controller
interface beam_sweep_controller_if #(parameter int NUM_ANGLES = 16, parameter int ENERGY_W = 32);
  localparam int AW = $clog2(NUM_ANGLES);
  logic start, abort, continuous, sample_valid;
  logic signed [15:0] beam_sample;
  logic [beamform_pkg::NUM_RX-1:0][beamform_pkg::DELAY_W-1:0] delay_out;
  logic delay_load, busy, energy_valid, sweep_done;
  logic [AW-1:0] angle_idx, best_angle;
  logic [ENERGY_W-1:0] energy_out, best_energy;
  modport master (
    output start, abort, continuous, sample_valid, beam_sample,
    input delay_out, delay_load, angle_idx, busy, energy_out, energy_valid, best_angle, best_energy, sweep_done
  );
  modport slave (
    input start, abort, continuous, sample_valid, beam_sample,
    output delay_out, delay_load, angle_idx, busy, energy_out, energy_valid, best_angle, best_energy, sweep_done
  );
endinterface

// File: rtl/steer_delay_lut.sv
// steer_delay_lut: steering angle to per-receiver delay set
module steer_delay_lut
  import beamform_pkg::*;
#(parameter int NUM_ANGLES = 16) (
  input  logic [$clog2(NUM_ANGLES)-1:0]   angle,
  output logic [NUM_RX-1:0][DELAY_W-1:0] delay
);
  // evaluate the steering rule for every receiver
  always_comb for (int c = 0; c < NUM_RX; c++) delay[c] = DELAY_W'(steer_delay(int'(angle), c, NUM_ANGLES));
endmodule

// File: rtl/beam_sweep_controller.sv
// beam_sweep_controller: sweeps steering angles, integrates beam energy per angle, tracks the strongest
module beam_sweep_controller
  import beamform_pkg::*;
#(
  parameter int NUM_ANGLES = 16,
  parameter int SETTLE_SAMPLES = 32,
  parameter int WINDOW = 256,
  parameter int ENERGY_W = 32
) (
  input logic clk,
  input logic rst,
  beam_sweep_controller_if.slave sif
);
  localparam int AW = $clog2(NUM_ANGLES);
  localparam int CW = $clog2((SETTLE_SAMPLES > WINDOW ? SETTLE_SAMPLES : WINDOW) + 1);
  if ((NUM_ANGLES / 2) * (NUM_RX - 1) >= 2 ** DELAY_W) begin : g_delay_range
    $error("steering delay range exceeds beamformer buffer depth");
  end
  sweep_state_t state, nxt;
  logic [AW-1:0] nxt_angle, run_angle;
  logic [CW-1:0] cnt, cnt_inc;
  logic [ENERGY_W-1:0] acc, acc_add, run_energy;
  logic [16:0] mag;
  logic [NUM_RX-1:0][DELAY_W-1:0] lut_delay;
  logic last;
  steer_delay_lut #(.NUM_ANGLES(NUM_ANGLES)) u_lut (.angle(nxt_angle), .delay(lut_delay));
  // sample magnitude (17 bits so -32768 maps to 32768) and running increments
  always_comb begin
    mag = sif.beam_sample[15] ? -{1'b1, sif.beam_sample} : {1'b0, sif.beam_sample};
    cnt_inc = cnt + 1'b1;
    acc_add = acc + ENERGY_W'(mag);
    last = sif.angle_idx == AW'(NUM_ANGLES - 1);
  end
  // next state and next angle; abort overrides every transition
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = sif.start ? LOAD : IDLE;
      LOAD:    nxt = SETTLE;
      SETTLE:  nxt = sif.sample_valid && cnt_inc == CW'(SETTLE_SAMPLES) ? CAPTURE : SETTLE;
      CAPTURE: nxt = sif.sample_valid && cnt_inc == CW'(WINDOW) ? REPORT : CAPTURE;
      REPORT:  nxt = last ? DONE : LOAD;
      DONE:    nxt = sif.continuous ? LOAD : IDLE;
      default: nxt = IDLE;
    endcase
    if (sif.abort && state != IDLE) nxt = IDLE;
    nxt_angle = nxt != LOAD ? sif.angle_idx : state == REPORT ? sif.angle_idx + 1'b1 : '0;
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // registered outputs follow the state being entered; running best kept per sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      sif.delay_out <= '0;
      sif.delay_load <= 1'b0;
      sif.energy_valid <= 1'b0;
      sif.sweep_done <= 1'b0;
      sif.busy <= 1'b0;
      sif.angle_idx <= '0;
      sif.energy_out <= '0;
      sif.best_angle <= '0;
      sif.best_energy <= '0;
      cnt <= '0;
      acc <= '0;
      run_angle <= '0;
      run_energy <= '0;
    end else begin
      sif.delay_load <= nxt == LOAD;
      sif.energy_valid <= nxt == REPORT;
      sif.sweep_done <= nxt == DONE;
      sif.busy <= nxt != IDLE;
      sif.angle_idx <= nxt_angle;
      cnt <= nxt != state ? '0 : sif.sample_valid ? cnt_inc : cnt;
      acc <= state == LOAD ? '0 : state == CAPTURE && sif.sample_valid ? acc_add : acc;
      if (nxt == LOAD) sif.delay_out <= lut_delay;
      if (nxt == REPORT) sif.energy_out <= acc_add;
      if (nxt == REPORT && acc_add > run_energy) begin
        run_energy <= acc_add;
        run_angle <= sif.angle_idx;
      end
      if (nxt == LOAD && state != REPORT) begin
        run_energy <= '0;
        run_angle <= '0;
      end
      if (nxt == DONE) begin
        sif.best_energy <= run_energy;
        sif.best_angle <= run_angle;
      end
    end
  end
endmodule

// File: tb/tb_beam_sweep_controller.sv
// tb_beam_sweep_controller: directed and randomized sweeps against a timeline model of the controller
module tb_beam_sweep_controller;
  localparam int NA = 4, SET = 2, WIN = 4, MAXC = 1024;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  beam_sweep_controller_if #(.NUM_ANGLES(NA), .ENERGY_W(32)) bif ();
  beam_sweep_controller #(.NUM_ANGLES(NA), .SETTLE_SAMPLES(SET), .WINDOW(WIN), .ENERGY_W(32)) dut (
    .clk(clk), .rst(rst), .sif(bif.slave)
  );
  int tbl [NA][4] = '{'{6, 4, 2, 0}, '{3, 2, 1, 0}, '{0, 0, 0, 0}, '{0, 1, 2, 3}};
  int n_checks = 0, n_errors = 0;
  bit sv_a [MAXC], st_a [MAXC], ct_a [MAXC], ab_a [MAXC];
  logic [15:0] bs_a [MAXC];
  int ld [MAXC], rp [MAXC], dn_a [MAXC], dn_e [MAXC];
  bit dn [MAXC];
  bit e_load [MAXC], e_ev [MAXC], e_done [MAXC], e_busy [MAXC];
  int e_ang [MAXC], e_dl [MAXC], e_en [MAXC], e_ba [MAXC], e_be [MAXC];
  int cur_ang = 0, cur_dl = -1, cur_en = 0, cur_ba = 0, cur_be = 0;
  int n_cyc, cap1;
  int done_at [$], load_at [$];

  function automatic int mag(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    return v < 0 ? -v : v;
  endfunction

  function automatic logic [19:0] dexp(input int a);
    logic [19:0] r;
    r = '0;
    if (a >= 0) for (int ch = 0; ch < 4; ch++) r[ch*5 +: 5] = 5'(tbl[a][ch]);
    return r;
  endfunction

  function automatic int qget(input int q [$], input int i);
    return q.size() > i ? q[i] : -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected timeline from the sweep rules: each angle loads, discards SET strobes,
  // sums WIN magnitudes, reports the cycle after its last strobe, and the next load follows.
  task automatic plan(input int sweeps, input int abort_at);
    int t, c, k, acc, ra, re, endc;
    for (int i = 0; i < MAXC; i++) begin
      ld[i] = -1; rp[i] = -1; dn[i] = 0; st_a[i] = 0; ct_a[i] = 0; ab_a[i] = 0;
    end
    t = 1; endc = 0; cap1 = 0;
    for (int s = 0; s < sweeps; s++) begin
      ra = 0; re = 0;
      for (int a = 0; a < NA; a++) begin
        ld[t] = a; c = t + 1; k = 0; acc = 0;
        while (k < SET + WIN) begin
          if (sv_a[c]) begin
            if (k >= SET) acc += mag(bs_a[c]);
            if (k == SET && a == 1 && s == 0) cap1 = c;
            k++;
          end
          c++;
        end
        rp[c] = acc;
        if (acc > re) begin re = acc; ra = a; end
        t = c + 1;
      end
      dn[t] = 1; dn_a[t] = ra; dn_e[t] = re; endc = t; t++;
    end
    st_a[0] = 1;
    for (int i = 1; i <= endc; i++) begin
      st_a[i] = $urandom_range(0, 7) == 0;
      ct_a[i] = sweeps > 1 && i < endc;
    end
    if (abort_at > 0) begin
      ab_a[abort_at] = 1;
      endc = abort_at;
      for (int i = abort_at + 1; i < MAXC; i++) begin st_a[i] = 0; ct_a[i] = 0; end
    end
    n_cyc = endc + 4;
    for (int i = 0; i <= n_cyc; i++) begin
      if (i == 0) begin
        e_ang[0] = cur_ang; e_dl[0] = cur_dl; e_en[0] = cur_en; e_ba[0] = cur_ba; e_be[0] = cur_be;
      end else begin
        e_ang[i] = e_ang[i-1]; e_dl[i] = e_dl[i-1]; e_en[i] = e_en[i-1]; e_ba[i] = e_ba[i-1]; e_be[i] = e_be[i-1];
      end
      e_busy[i] = i >= 1 && i <= endc;
      e_load[i] = e_busy[i] && ld[i] >= 0;
      e_ev[i] = e_busy[i] && rp[i] >= 0;
      e_done[i] = e_busy[i] && dn[i];
      if (e_load[i]) begin e_ang[i] = ld[i]; e_dl[i] = ld[i]; end
      if (e_ev[i]) e_en[i] = rp[i];
      if (e_done[i]) begin e_ba[i] = dn_a[i]; e_be[i] = dn_e[i]; end
    end
  endtask

  task automatic check_cycle(input int i);
    chk("delay_load", bif.delay_load, e_load[i]);
    chk("energy_valid", bif.energy_valid, e_ev[i]);
    chk("sweep_done", bif.sweep_done, e_done[i]);
    chk("busy", bif.busy, e_busy[i]);
    chk("angle_idx", bif.angle_idx, e_ang[i]);
    chk("delay_out", bif.delay_out, dexp(e_dl[i]));
    chk("energy_out", bif.energy_out, e_en[i]);
    chk("best_angle", bif.best_angle, e_ba[i]);
    chk("best_energy", bif.best_energy, e_be[i]);
    if (bif.sweep_done) done_at.push_back(i);
    if (bif.delay_load) load_at.push_back(i);
  endtask

  task automatic run_plan;
    done_at.delete();
    load_at.delete();
    for (int i = 0; i < n_cyc; i++) begin
      @(negedge clk);
      bif.start = st_a[i]; bif.sample_valid = sv_a[i]; bif.beam_sample = bs_a[i];
      bif.abort = ab_a[i]; bif.continuous = ct_a[i];
      @(posedge clk);
      #1;
      check_cycle(i + 1);
    end
    cur_ang = e_ang[n_cyc]; cur_dl = e_dl[n_cyc]; cur_en = e_en[n_cyc]; cur_ba = e_ba[n_cyc]; cur_be = e_be[n_cyc];
    @(negedge clk);
    bif.start = 0; bif.sample_valid = 0; bif.abort = 0; bif.continuous = 0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_delay_load"}, bif.delay_load, 0);
    chk({tag, "_energy_valid"}, bif.energy_valid, 0);
    chk({tag, "_sweep_done"}, bif.sweep_done, 0);
    chk({tag, "_busy"}, bif.busy, 0);
    chk({tag, "_angle_idx"}, bif.angle_idx, 0);
    chk({tag, "_delay_out"}, bif.delay_out, 0);
    chk({tag, "_energy_out"}, bif.energy_out, 0);
    chk({tag, "_best_angle"}, bif.best_angle, 0);
    chk({tag, "_best_energy"}, bif.best_energy, 0);
  endtask

  initial begin
    bif.start = 0; bif.abort = 0; bif.continuous = 0; bif.sample_valid = 0; bif.beam_sample = '0;
    // reset for two cycles with sample activity, then idle strobes
    repeat (2) begin
      @(negedge clk);
      bif.sample_valid = 1; bif.beam_sample = 16'h8000;
      @(posedge clk);
      #1;
      check_quiet("reset");
    end
    @(negedge clk);
    rst = 0;
    repeat (4) begin
      @(negedge clk);
      bif.sample_valid = 1; bif.beam_sample = 16'($urandom);
      @(posedge clk);
      #1;
      check_quiet("idle");
    end
    @(negedge clk);
    bif.sample_valid = 0;
    // constant -3 with continuous strobes
    for (int i = 0; i < MAXC; i++) begin sv_a[i] = 1; bs_a[i] = 16'hFFFD; end
    plan(1, -1);
    run_plan();
    chk("const_first_load", qget(load_at, 0), 1);
    chk("const_done_cycle", qget(done_at, 0), 33);
    chk("const_best_angle", bif.best_angle, 0);
    chk("const_best_energy", bif.best_energy, 12);
    // peak of -32768 during angle 2 capture
    for (int i = 0; i < MAXC; i++) begin sv_a[i] = 1; bs_a[i] = (i >= 20 && i <= 23) ? 16'h8000 : 16'd1; end
    plan(1, -1);
    run_plan();
    chk("peak_best_angle", bif.best_angle, 2);
    chk("peak_best_energy", bif.best_energy, 131072);
    // sparse strobes every third cycle
    for (int i = 0; i < MAXC; i++) begin sv_a[i] = i % 3 == 0; bs_a[i] = 16'hFFFD; end
    plan(1, -1);
    run_plan();
    chk("sparse_best_angle", bif.best_angle, 0);
    chk("sparse_best_energy", bif.best_energy, 12);
    // random samples, abort during angle 1 capture
    for (int i = 0; i < MAXC; i++) begin sv_a[i] = $urandom_range(0, 1) == 1 || i % 4 == 0; bs_a[i] = 16'($urandom); end
    plan(1, -1);
    plan(1, cap1);
    run_plan();
    chk("abort_no_done", done_at.size(), 0);
    chk("abort_best_energy", bif.best_energy, 12);
    chk("abort_angle_held", bif.angle_idx, 1);
    // random full sweep after the abort
    for (int i = 0; i < MAXC; i++) begin sv_a[i] = $urandom_range(0, 1) == 1 || i % 4 == 0; bs_a[i] = 16'($urandom); end
    plan(1, -1);
    run_plan();
    chk("rand_done_count", done_at.size(), 1);
    // continuous mode, three sweeps, random samples and stray starts
    for (int i = 0; i < MAXC; i++) begin sv_a[i] = 1; bs_a[i] = 16'($urandom); end
    plan(3, -1);
    run_plan();
    chk("cont_done_count", done_at.size(), 3);
    chk("cont_done0", qget(done_at, 0), 33);
    chk("cont_done1", qget(done_at, 1), 66);
    chk("cont_done2", qget(done_at, 2), 99);
    chk("cont_load34", qget(load_at, 4), 34);
    chk("cont_load67", qget(load_at, 8), 67);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/beam_sweep_controller.md
# beam_sweep_controller

Sequencer for the receive beamformer's steering delays. It sweeps a set of steering angles and, for each angle, loads the per-receiver delay set into the beamformer. It then waits for the delay buffers to settle, integrates |aggregated sample| over a fixed window, and reports per-angle energy. At the end of each sweep it reports the strongest angle. It sits between the ADC/beamformer datapath and the display/ranging logic.

## Interface
- NUM_RX, 4, receiver channels
- NUM_ANGLES, 16, steering positions per sweep (power of two, ≥2)
- DELAY_W, 5, per-channel delay width (beamformer buffer depth 32)
- SETTLE_SAMPLES, 32, samples discarded after each delay load
- WINDOW, 256, samples integrated per angle (power of two)
- ENERGY_W, 32, accumulator/energy width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin sweep (pulse; ignored while busy)
- abort  in  1  cancel sweep
- continuous  in  1  restart sweep automatically after completion
- sample_valid  in  1  beamformer output sample strobe
- beam_sample  in  16  signed aggregated waveform sample
- delay_out  out  NUM_RX×DELAY_W  per-channel delay to beamformer, held between loads
- delay_load  out  1  one-cycle pulse when delay_out changes
- angle_idx  out  $clog2(NUM_ANGLES)  current angle
- busy  out  1  high in any state but IDLE
- energy_out  out  ENERGY_W  per-angle energy
- energy_valid  out  1  one-cycle strobe qualifying energy_out and angle_idx
- best_angle  out  $clog2(NUM_ANGLES)  strongest angle of last completed sweep
- best_energy  out  ENERGY_W  its energy
- sweep_done  out  1  one-cycle pulse at end of sweep

## Operation
- Steering: s = angle_idx − NUM_ANGLES/2 (signed).
  - s ≥ 0: delay[ch] = s·ch.
  - s < 0: delay[ch] = |s|·(NUM_RX−1−ch).
  - Max delay = (NUM_ANGLES/2)·(NUM_RX−1) must be < 2^DELAY_W; checked by elaboration assertion.
- FSM states: IDLE, LOAD, SETTLE, CAPTURE, REPORT, DONE.
  - IDLE: start=1 → LOAD; angle_idx←0; internal running best cleared (energy 0, angle 0).
  - LOAD (1 cycle): delay_out ← table(angle_idx); delay_load=1; clear the settle counter and the accumulator; → SETTLE.
  - SETTLE: count sample_valid strobes. The strobe bringing the count to SETTLE_SAMPLES is the last discarded sample; → CAPTURE.
  - CAPTURE: on each sample_valid, acc += |beam_sample|. |−32768| = 32768 (17-bit unsigned, zero-extended to ENERGY_W). After the WINDOW-th strobe → REPORT.
  - REPORT (1 cycle): energy_out←acc; energy_valid=1. If acc > running best (strict; ties keep the lower angle), update the running best. If angle_idx = NUM_ANGLES−1 → DONE; else angle_idx++ → LOAD.
  - DONE (1 cycle): sweep_done=1; best_angle/best_energy ← running best. continuous=1 → LOAD with angle_idx←0 and the running best cleared; else → IDLE.
- sample_valid in IDLE, LOAD, REPORT or DONE is ignored.
- abort (any non-IDLE state): → IDLE next cycle. No energy_valid or sweep_done is produced. best_* hold their previous values. delay_out holds. abort has priority over start and over every transition.
- start while busy: ignored.

## Timing
- All outputs are registered.
- Reset values: delay_out all 0, angle_idx 0, all strobes 0, busy 0, energy_out 0, best_* 0, state IDLE.
- start sampled at cycle t → LOAD at t+1 (delay_load high, new delay_out visible, busy high).
- With sample_valid tied high, each angle takes 1 + SETTLE_SAMPLES + WINDOW + 1 cycles.
- A sweep ends with DONE one cycle after the last REPORT. busy falls the cycle after DONE, unless continuous.
- best_* are updated only in DONE and are stable between sweeps.
- rst mid-sweep: full reset, including best_*.

## Structure
- Shared package beamform_pkg holds:
  - NUM_RX and the buffer depth 32 (shared with the beamformer).
  - The function steer_delay(angle, ch).
  - The state enum.
- Sub-module steer_delay_lut: combinational angle → NUM_RX delays, built from steer_delay. The controller registers its output in LOAD.

## Test plan
Use NUM_ANGLES=4, SETTLE_SAMPLES=2, WINDOW=4 unless stated.
- Reset: rst for 2 cycles → every output 0, busy 0; sample_valid activity produces no strobes.
- Delay table: start at cycle 0 → delay_load at cycle 1 with delay_out {ch0..3} = {6,4,2,0}. Subsequent loads: angle1 = {3,2,1,0}, angle2 = {0,0,0,0}, angle3 = {0,1,2,3}.
- Constant input: sample_valid=1, beam_sample=−3 → energy_valid at cycles 8/16/24/32 with energy 12 each; sweep_done at cycle 33; best_angle 0 (tie rule); best_energy 12; busy low at cycle 34.
- Peak detection: beam_sample=1 except −32768 during angle 2 CAPTURE → energies 4, 4, 131072, 4; best_angle 2; best_energy 131072.
- Sparse strobes and abort: sample_valid every 3rd cycle → the same energies as the constant-input test. Second sweep: abort during angle 1 CAPTURE → IDLE next cycle, no energy_valid, best_* unchanged. A new start then runs a full sweep normally.
- Continuous mode: continuous=1 → sweep_done at cycles 33, 66, 99; LOAD of angle 0 at cycles 34 and 67; start pulses mid-sweep are ignored.
